calc_disp_drv: RTL and testbench
================================

// Module: calc_disp_drv
// PURPOSE
//  Downstream of the calculator core. Consumes its serial digit stream (status, data, pos)
//  and assembles 8 BCD digits into a frame buffer. Drives a time-multiplexed 8-digit
//  common-anode seven-segment display. Shows a fixed error pattern when the core reports error.
// PARAMETERS
//  SCAN_DIV    50000  clock cycles per digit slot (>=2); scan period = 8*SCAN_DIV
//  NUM_DIGITS  8      digit count; fixed at 8, kept as a named constant only
// PORTS
//  clock        in   1  system clock; single clock domain
//  reset        in   1  synchronous, active-high reset
//  status       in   2  core status: 00 erro, 01 ocupado, 10 pronto, 11 reserved
//  data         in   4  BCD digit for position pos
//  pos          in   4  digit index 0..7; values >7 are ignored
//  an           out  8  digit enables, active-low, one-hot (bit i = digit i, 0 = LSD)
//  seg          out  8  {dp,g,f,e,d,c,b,a}, active-low; dp is always 1 (off)
//  frame_valid  out  1  one-cycle pulse when a new frame is committed
// BEHAVIOUR
//  Reset (synchronous, active-high): state=SHOW, frame[*]=0, shadow[*]=0, an=8'hFF,
//   seg=8'hFF, frame_valid=0, scan index=0, prescaler=0. Reset mid-capture discards the shadow.
//  FSM states: SHOW, CAPTURE, ERR.
//   SHOW -> CAPTURE when status==01 && pos==0. shadow[0]<=data is written in that same cycle.
//   CAPTURE: each cycle with status==01 && pos<=7, shadow[pos]<=data.
//    pos==7 written -> frame<=shadow (including digit 7 from this cycle) on the next edge,
//    frame_valid=1 for exactly that cycle, state -> SHOW.
//    status==10 or 11 before pos==7 -> abort, frame unchanged, state -> SHOW.
//   Any state with status==00 -> ERR (highest priority, even while capturing).
//   ERR is sticky; it exits only on reset.
//  A frame is committed only as a full 0..7 sweep. Repeated or out-of-order pos values
//   overwrite their shadow slot.
//  Scan: prescaler counts 0..SCAN_DIV-1. On wrap, scan index increments 7->0.
//   an and seg are registered. They update one cycle after the prescaler wrap and stay
//   stable for SCAN_DIV cycles.
//  Decode (SHOW/CAPTURE): the displayed digit is taken from frame, never from shadow.
//   0-9 standard glyphs; codes 10-15 show '-' (only g lit).
//  ERR: digits 3..0 show "Erro" (E,r,r,o glyphs); digits 7..4 blank (seg=8'hFF).
//   The scan keeps running.
//  Simultaneous commit and scan tick: the new frame is visible from the next slot.
//   The slot in progress is not glitched.
// CONFIGURATION
//  CALC_DISP_LZB_EN defined: leading-zero blanking.
//   Digits above the most significant non-zero frame digit are blanked (seg=8'hFF).
//   Digit 0 is always shown, so value 0 shows a single '0'.
//   Blanking is computed from the committed frame and registered with the commit.
//   Not applied in ERR.
//  CALC_DISP_LZB_EN undefined: all 8 digits are always displayed, including leading zeros.
// STRUCTURE
//  Package calc_disp_pkg:
//   status localparams ST_ERRO=2'b00, ST_OCUPADO=2'b01, ST_PRONTO=2'b10
//   FSM state enum (SHOW, CAPTURE, ERR)
//   active-low glyph constants SEG_BLANK, SEG_DASH, SEG_E, SEG_R, SEG_O
//   function bcd_to_seg(logic [3:0]) -> logic [7:0]
//  Sub-module calc_disp_scan: prescaler plus 3-bit slot index.
//   Outputs slot index and a one-cycle tick.
//  Capture FSM, frame and shadow buffers, and decode live in calc_disp_drv.
// TESTING
//  (bench uses SCAN_DIV=4)
//  1 Reset: after reset release, an=8'hFF and seg=8'hFF for 1 cycle, then the scan starts at digit 0.
//    Frame is all zeros (LZB off: 8x '0').
//  2 Sweep status=01, pos=0..7 with data=1..8 -> frame_valid pulses once, 1 cycle after pos=7.
//    an=8'b11111110 shows '1'; an=8'b01111111 shows '8'.
//  3 Abort: sweep pos=0..3, then status=10 -> no frame_valid; previous frame still displayed.
//  4 status=00 mid-sweep -> ERR. Digits 3..0 show E,r,r,o and digits 7..4 are blank.
//    Stays in ERR after status=10 until reset.
//  5 data=4'hC at pos 2 -> digit 2 shows '-' (seg=8'b10111111).
//  6 With CALC_DISP_LZB_EN, frame value 00000042 -> only digits 1 and 0 lit ('4','2').
//    Frame value 0 -> only digit 0 lit ('0').

Source files
------------

// File: rtl/calc_disp_pkg.sv
// Shared definitions for the calculator display driver: core status codes, FSM states
// and active-low seven-segment glyphs ({dp,g,f,e,d,c,b,a}, 0 = segment lit).
package calc_disp_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [1:0] ST_ERRO    = 2'b00;
  localparam logic [1:0] ST_OCUPADO = 2'b01;
  localparam logic [1:0] ST_PRONTO  = 2'b10;

  typedef enum logic [1:0] {
    SHOW,
    CAPTURE,
    ERR
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_R     = 8'hAF;
  localparam logic [7:0] SEG_O     = 8'hA3;

  // Codes 10-15 are not valid BCD; they render as a dash so bad data is visible.
  function automatic logic [7:0] bcd_to_seg(input logic [3:0] bcd);
    logic [7:0] glyph;
    case (bcd)
      4'd0:    glyph = 8'hC0;
      4'd1:    glyph = 8'hF9;
      4'd2:    glyph = 8'hA4;
      4'd3:    glyph = 8'hB0;
      4'd4:    glyph = 8'h99;
      4'd5:    glyph = 8'h92;
      4'd6:    glyph = 8'h82;
      4'd7:    glyph = 8'hF8;
      4'd8:    glyph = 8'h80;
      4'd9:    glyph = 8'h90;
      default: glyph = SEG_DASH;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/calc_disp_scan.sv
// Digit-slot timebase: a prescaler of SCAN_DIV cycles and a 3-bit slot index.
// tick marks the first cycle of every slot, including the first one after reset.
module calc_disp_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset,
  output logic [2:0] slot,
  output logic       tick
);

  localparam int PW = $clog2(SCAN_DIV);

  logic [PW-1:0] prescaler;
  logic          wrap;

  assign wrap = (prescaler == PW'(SCAN_DIV - 1));
  assign tick = (prescaler == '0);

  // The slot index is 3 bits wide, so it wraps from 7 back to 0 on its own.
  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler <= '0;
      slot      <= 3'd0;
    end else if (wrap) begin
      prescaler <= '0;
      slot      <= slot + 3'd1;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

endmodule

// File: rtl/calc_disp_drv.sv
// Calculator display driver: captures the core's digit stream into a frame and scans it
// onto an 8-digit common-anode display. Define CALC_DISP_LZB_EN for leading-zero blanking.
module calc_disp_drv #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [7:0] seg,
  output logic       frame_valid
);

  import calc_disp_pkg::*;

  state_t                         state, state_next;
  logic [NUM_DIGITS-1:0][3:0]     frame, shadow, commit_frame;
  logic [NUM_DIGITS-1:0]          blank_mask;
  logic                           shadow_we, commit, pos_ok;
  logic [2:0]                     slot;
  logic                           tick;
  logic [7:0]                     seg_next;

  calc_disp_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clock (clock),
    .reset (reset),
    .slot  (slot),
    .tick  (tick)
  );

  assign pos_ok = ~pos[3];

  // An error report overrides everything, including a capture in progress.
  always_comb begin
    state_next = state;
    shadow_we  = 1'b0;
    commit     = 1'b0;
    if (status == ST_ERRO) begin
      state_next = ERR;
    end else begin
      case (state)
        SHOW: begin
          if (status == ST_OCUPADO && pos == 4'd0) begin
            state_next = CAPTURE;
            shadow_we  = 1'b1;
          end
        end
        CAPTURE: begin
          if (status == ST_OCUPADO) begin
            if (pos_ok) begin
              shadow_we = 1'b1;
              if (pos[2:0] == 3'd7) begin
                commit     = 1'b1;
                state_next = SHOW;
              end
            end
          end else begin
            state_next = SHOW;
          end
        end
        ERR:     state_next = ERR;
        default: state_next = SHOW;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= SHOW;
    else       state <= state_next;
  end

  // The committed frame must include digit 7 arriving in the commit cycle itself.
  always_comb begin
    commit_frame    = shadow;
    commit_frame[7] = data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow      <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
    end else begin
      if (shadow_we) shadow[pos[2:0]] <= data;
      if (commit)    frame <= commit_frame;
      frame_valid <= commit;
    end
  end

`ifdef CALC_DISP_LZB_EN
  // Digit 0 is never blanked so an all-zero frame still shows a single '0'.
  function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [NUM_DIGITS-1:0][3:0] f);
    logic [NUM_DIGITS-1:0] mask;
    logic                  all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero && (f[i] == 4'd0);
      mask[i]  = all_zero;
    end
    return mask;
  endfunction

  always_ff @(posedge clock) begin
    if (reset)       blank_mask <= 8'hFE;
    else if (commit) blank_mask <= lead_zero_mask(commit_frame);
  end
`else
  assign blank_mask = '0;
`endif

  always_comb begin
    seg_next = SEG_BLANK;
    if (state == ERR) begin
      case (slot)
        3'd3:        seg_next = SEG_E;
        3'd2, 3'd1:  seg_next = SEG_R;
        3'd0:        seg_next = SEG_O;
        default:     seg_next = SEG_BLANK;
      endcase
    end else if (!blank_mask[slot]) begin
      seg_next = bcd_to_seg(frame[slot]);
    end
  end

  // Loading only at slot start keeps a slot stable even if a commit lands mid-slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= SEG_BLANK;
    end else if (tick) begin
      an  <= ~(8'b1 << slot);
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_calc_disp_drv.sv
// Self-checking bench for calc_disp_drv with SCAN_DIV=4, randomized sweeps and a
// behavioural frame/display model; follows CALC_DISP_LZB_EN if defined.
module tb_calc_disp_drv;

  localparam int SCAN_DIV = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] status = 2'b10;
  logic [3:0] data = 4'd0;
  logic [3:0] pos = 4'd0;
  logic [7:0] an, seg;
  logic       frame_valid;

  int tests_run = 0;
  int tests_failed = 0;

  int m_frame[8];
  int m_shadow[8];
  bit m_err, m_capt;
  int exp_fv = 0;
  int obs_fv = 0;

  calc_disp_drv #(.SCAN_DIV(SCAN_DIV)) dut (
    .clock       (clock),
    .reset       (reset),
    .status      (status),
    .data        (data),
    .pos         (pos),
    .an          (an),
    .seg         (seg),
    .frame_valid (frame_valid)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] glyph(input int v);
    case (v)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hBF;
    endcase
  endfunction

  function automatic logic [7:0] expect_seg(input int idx);
    int msd;
    if (m_err) begin
      case (idx)
        3: return 8'h86;
        2, 1: return 8'hAF;
        0: return 8'hA3;
        default: return 8'hFF;
      endcase
    end
    msd = 0;
    for (int i = 0; i < 8; i++) if (m_frame[i] != 0) msd = i;
`ifdef CALC_DISP_LZB_EN
    if (idx > msd) return 8'hFF;
`endif
    return glyph(m_frame[idx]);
  endfunction

  // One clock of stimulus; the model applies the capture rules to the same inputs.
  task automatic drive_cycle(input logic [1:0] st, input int p, input int d);
    status = st;
    pos    = p[3:0];
    data   = d[3:0];
    @(posedge clock);
    #1;
    if (frame_valid === 1'b1) obs_fv++;
    if (st == 2'b00) begin
      m_err  = 1;
      m_capt = 0;
    end else if (!m_err) begin
      if (!m_capt) begin
        if (st == 2'b01 && p == 0) begin
          m_capt      = 1;
          m_shadow[0] = d;
        end
      end else if (st == 2'b01) begin
        if (p <= 7) begin
          m_shadow[p] = d;
          if (p == 7) begin
            m_frame = m_shadow;
            m_capt  = 0;
            exp_fv++;
          end
        end
      end else begin
        m_capt = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(2'b10, 0, 0);
  endtask

  task automatic wait_an(input logic [7:0] target, output bit ok);
    ok = 0;
    for (int c = 0; c < 10 * SCAN_DIV; c++) begin
      if (an === target) begin
        ok = 1;
        break;
      end
      idle(1);
    end
  endtask

  task automatic apply_reset();
    reset  = 1'b1;
    status = 2'b10;
    pos    = 4'd0;
    data   = 4'd0;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    for (int i = 0; i < 8; i++) begin
      m_frame[i]  = 0;
      m_shadow[i] = 0;
    end
    m_err  = 0;
    m_capt = 0;
    reset  = 1'b0;
  endtask

  task automatic sweep(input int digits[8]);
    for (int p = 0; p < 8; p++) drive_cycle(2'b01, p, digits[p]);
  endtask

  task automatic check_display(input string name);
    logic [7:0] last_an;
    logic [7:0] seen;
    int         idx;
    idle(2 * SCAN_DIV);
    last_an = an;
    seen    = 8'h00;
    for (int c = 0; c < 10 * SCAN_DIV && seen != 8'hFF; c++) begin
      idle(1);
      if (an !== last_an) begin
        last_an = an;
        tests_run++;
        if ($countones(~an) != 1) begin
          tests_failed++;
          $display("[TB] FAIL %s onehot: an=%b", name, an);
        end else begin
          idx = 0;
          for (int i = 0; i < 8; i++) if (an[i] === 1'b0) idx = i;
          seen[idx] = 1'b1;
          tests_run++;
          if (seg !== expect_seg(idx)) begin
            tests_failed++;
            $display("[TB] FAIL %s digit%0d: seg=%h expected=%h", name, idx, seg, expect_seg(idx));
          end
        end
      end
    end
    tests_run++;
    if (seen !== 8'hFF) begin
      tests_failed++;
      $display("[TB] FAIL %s scan coverage: seen=%b expected=11111111", name, seen);
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp_an;
    apply_reset();
    tests_run++;
    if (an !== 8'hFF || seg !== 8'hFF) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: an=%h seg=%h expected=ff/ff", an, seg);
    end
    for (int n = 1; n <= 33; n++) begin
      idle(1);
      exp_an = ~(8'b1 << (((n - 1) / SCAN_DIV) % 8));
      tests_run++;
      if (an !== exp_an || frame_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL scan_order n=%0d: an=%b fv=%b expected an=%b fv=0", n, an, frame_valid, exp_an);
      end
      if (n == 1) begin
        tests_run++;
        if (seg !== 8'hC0) begin
          tests_failed++;
          $display("[TB] FAIL reset_digit0: seg=%h expected=c0", seg);
        end
      end
    end
    check_display("reset_frame");
  endtask

  task automatic test_sweep();
    int digits[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    bit ok;
    for (int p = 0; p < 7; p++) drive_cycle(2'b01, p, digits[p]);
    tests_run++;
    if (frame_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL sweep_early_fv: fv=%b expected=0", frame_valid);
    end
    drive_cycle(2'b01, 7, digits[7]);
    tests_run++;
    if (frame_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL sweep_fv_pulse: fv=%b expected=1", frame_valid);
    end
    idle(1);
    tests_run++;
    if (frame_valid !== 1'b0 || obs_fv != exp_fv) begin
      tests_failed++;
      $display("[TB] FAIL sweep_fv_single: fv=%b pulses=%0d expected fv=0 pulses=%0d", frame_valid, obs_fv, exp_fv);
    end
    wait_an(8'b11111110, ok);
    tests_run++;
    if (!ok || seg !== 8'hF9) begin
      tests_failed++;
      $display("[TB] FAIL sweep_digit0: found=%0d seg=%h expected=f9", ok, seg);
    end
    wait_an(8'b01111111, ok);
    tests_run++;
    if (!ok || seg !== 8'h80) begin
      tests_failed++;
      $display("[TB] FAIL sweep_digit7: found=%0d seg=%h expected=80", ok, seg);
    end
    check_display("sweep");
  endtask

  task automatic test_random_sweeps();
    int digits[8];
    int top;
    for (int k = 0; k < 6; k++) begin
      top = $urandom_range(0, 7);
      for (int i = 0; i < 8; i++) digits[i] = (i <= top) ? $urandom_range(0, 15) : 0;
      for (int p = 0; p < 7; p++) begin
        drive_cycle(2'b01, p, digits[p]);
        if ($urandom_range(0, 3) == 0) drive_cycle(2'b01, $urandom_range(8, 15), $urandom_range(0, 15));
        if (p > 0 && $urandom_range(0, 3) == 0) drive_cycle(2'b01, p, digits[p]);
      end
      drive_cycle(2'b01, 7, digits[7]);
      idle(1);
      tests_run++;
      if (obs_fv != exp_fv) begin
        tests_failed++;
        $display("[TB] FAIL random_fv k=%0d: pulses=%0d expected=%0d", k, obs_fv, exp_fv);
      end
      check_display($sformatf("random%0d", k));
    end
  endtask

  task automatic test_dash();
    int digits[8] = '{1, 1, 12, 1, 1, 1, 1, 1};
    bit ok;
    sweep(digits);
    wait_an(8'b11111011, ok);
    idle(2 * SCAN_DIV);
    wait_an(8'b11111011, ok);
    tests_run++;
    if (!ok || seg !== 8'b10111111) begin
      tests_failed++;
      $display("[TB] FAIL dash_digit2: found=%0d seg=%b expected=10111111", ok, seg);
    end
    check_display("dash");
  endtask

  task automatic test_abort();
    int fv_before;
    fv_before = obs_fv;
    for (int p = 0; p < 4; p++) drive_cycle(2'b01, p, $urandom_range(0, 9));
    drive_cycle(2'b10, 0, 0);
    drive_cycle(2'b01, 7, 9);
    idle(2);
    tests_run++;
    if (obs_fv != fv_before) begin
      tests_failed++;
      $display("[TB] FAIL abort_fv: pulses=%0d expected=%0d", obs_fv, fv_before);
    end
    check_display("abort");
  endtask

`ifdef CALC_DISP_LZB_EN
  task automatic test_lzb();
    int d42[8] = '{2, 4, 0, 0, 0, 0, 0, 0};
    int dz[8]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    bit ok;
    sweep(d42);
    idle(2 * SCAN_DIV);
    wait_an(8'b11111101, ok);
    tests_run++;
    if (!ok || seg !== 8'h99) begin
      tests_failed++;
      $display("[TB] FAIL lzb_digit1: found=%0d seg=%h expected=99", ok, seg);
    end
    wait_an(8'b11111011, ok);
    tests_run++;
    if (!ok || seg !== 8'hFF) begin
      tests_failed++;
      $display("[TB] FAIL lzb_digit2: found=%0d seg=%h expected=ff", ok, seg);
    end
    check_display("lzb_42");
    sweep(dz);
    check_display("lzb_zero");
  endtask
`endif

  task automatic test_error();
    int fv_before;
    int digits[8] = '{3, 1, 4, 1, 5, 9, 2, 6};
    bit ok;
    fv_before = obs_fv;
    for (int p = 0; p < 4; p++) drive_cycle(2'b01, p, digits[p]);
    drive_cycle(2'b00, 0, 0);
    check_display("error");
    wait_an(8'b11110111, ok);
    tests_run++;
    if (!ok || seg !== 8'h86) begin
      tests_failed++;
      $display("[TB] FAIL error_digit3: found=%0d seg=%h expected=86", ok, seg);
    end
    idle(3);
    sweep(digits);
    idle(2);
    tests_run++;
    if (obs_fv != fv_before) begin
      tests_failed++;
      $display("[TB] FAIL error_sticky_fv: pulses=%0d expected=%0d", obs_fv, fv_before);
    end
    check_display("error_sticky");
  endtask

  task automatic test_reset_recover();
    int digits[8];
    apply_reset();
    check_display("recover_zero");
    for (int i = 0; i < 8; i++) digits[i] = $urandom_range(0, 9);
    sweep(digits);
    idle(1);
    tests_run++;
    if (obs_fv != exp_fv) begin
      tests_failed++;
      $display("[TB] FAIL recover_fv: pulses=%0d expected=%0d", obs_fv, exp_fv);
    end
    check_display("recover_frame");
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_random_sweeps();
    test_dash();
    test_abort();
`ifdef CALC_DISP_LZB_EN
    test_lzb();
`endif
    test_error();
    test_reset_recover();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
